// File: rtl/contador_pkg.sv
// Shared constants for the contador counter family.
//   DEFAULT_WIDTH : default count/data width
//   UP / DOWN     : values of the up_down input
//   WRAP / SAT    : values of the sat_mode input
package contador_pkg;

    localparam int   DEFAULT_WIDTH = 8;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

endpackage

// File: rtl/contador_addsub.sv
// Combinational add/subtract datapath for contador_param.
// Works at WIDTH+1 bits so neither the carry nor the borrow is lost, then
// wraps modulo MAX_VAL+1 or clamps to [0, MAX_VAL].
// Ports:
//   cnt_i      : current count
//   step_i     : magnitude to add or subtract
//   up_down_i  : UP adds, DOWN subtracts
//   sat_mode_i : SAT clamps, WRAP wraps
//   res_o      : next count value
//   ovf_o      : unclamped up result exceeded MAX_VAL
//   unf_o      : unclamped down result went below 0
module contador_addsub
    import contador_pkg::*;
#(
    parameter int              WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             up_down_i,
    input  logic             sat_mode_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [WIDTH:0] MAX_E = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MOD_E = MAX_E + (WIDTH+1)'(1);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] deficit;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] res_w;

    always_comb begin
        sum     = {1'b0, cnt_i} + {1'b0, step_i};
        // Both operands are below 2**WIDTH, so diff[WIDTH] is the borrow.
        diff    = {1'b0, cnt_i} - {1'b0, step_i};
        deficit = {1'b0, step_i} - {1'b0, cnt_i};
        rem     = '0;
        res_w   = '0;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (up_down_i == UP) begin
            ovf_o = (sum > MAX_E);
            if (!ovf_o)              res_w = sum;
            else if (sat_mode_i == SAT) res_w = MAX_E;
            else                     res_w = sum % MOD_E;  // step may exceed the modulus
        end else begin
            unf_o = diff[WIDTH];
            if (!unf_o)              res_w = diff;
            else if (sat_mode_i == SAT) res_w = '0;
            else begin
                // (cnt - step) mod M  ==  (M - (step - cnt) mod M) mod M
                rem   = deficit % MOD_E;
                res_w = (rem == '0) ? '0 : (MOD_E - rem);
            end
        end
        res_o = res_w[WIDTH-1:0];
    end

endmodule

// File: rtl/contador_param.sv
// Parameterised up/down counter with wrap/saturate modes, synchronous clear
// and load, target-hit detection and overflow/underflow pulses.
// Optional feature macro: CONTADOR_ERR_STICKY_EN adds err_clr / err_sticky.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   clear, load, en    : control, priority clear > load > en
//   load_val           : value to load (clamped to MAX_VAL)
//   up_down, step      : direction and magnitude of a count operation
//   sat_mode           : SAT clamps at bounds, WRAP wraps modulo MAX_VAL+1
//   target             : compare value for hit_target
//   err_clr            : (optional) clears err_sticky
//   count              : registered count
//   zero, at_max       : combinational decode of count
//   hit_target         : registered pulse, first cycle count reaches target
//   ovf, unf           : registered pulses from an out-of-range operation
//   err_sticky         : (optional) latched ovf/unf
module contador_param
    import contador_pkg::*;
#(
    parameter int              WIDTH     = DEFAULT_WIDTH,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] target,
`ifdef CONTADOR_ERR_STICKY_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             at_max,
    output logic             hit_target,
    output logic             ovf,
    output logic             unf
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("contador_param: WIDTH must be in 2..32");
    end
    if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("contador_param: MAX_VAL exceeds 2**WIDTH-1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_rst
        $error("contador_param: RESET_VAL exceeds MAX_VAL");
    end

    localparam logic [WIDTH:0]   MAX_E = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] as_res;
    logic             as_ovf, as_unf;

    contador_addsub #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_addsub (
        .cnt_i      (count_q),
        .step_i     (step),
        .up_down_i  (up_down),
        .sat_mode_i (sat_mode),
        .res_o      (as_res),
        .ovf_o      (as_ovf),
        .unf_o      (as_unf)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clear) begin
            count_d = RST_V;
        end else if (load) begin
            count_d = ({1'b0, load_val} > MAX_E) ? MAX_W : load_val;
        end else if (en) begin
            count_d = as_res;
            ovf_d   = as_ovf;
            unf_d   = as_unf;
        end
        // Only a real change of count can produce a hit; a moving target
        // or a held value never does.
        hit_d = (count_d == target) && (count_d != count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RST_V;
            hit_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef CONTADOR_ERR_STICKY_EN
    logic err_q, err_d;

    // A set condition beats err_clr both at the edge that raises the pulse
    // and during the cycle the pulse is visible on ovf/unf.
    always_comb begin
        err_d = err_q;
        if (ovf_d || unf_d || ovf_q || unf_q) err_d = 1'b1;
        else if (err_clr)                     err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_sticky = err_q;
`endif

    assign count      = count_q;
    assign zero       = (count_q == '0);
    assign at_max     = (count_q == MAX_W);
    assign hit_target = hit_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;

endmodule

// File: tb/tb_contador_param.sv
// Directed scoreboard bench for contador_param. Two instances share stimulus:
// instance A (MAX_VAL=9, RESET_VAL=0) and instance B (MAX_VAL=99, RESET_VAL=3).
module tb_contador_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0, load = 1'b0, en = 1'b0, up_down = 1'b1, sat_mode = 1'b0;
    logic [7:0] load_val = '0, step = '0, target = 8'd200;
    logic       err_clr = 1'b0;

    logic [7:0] count_a, count_b;
    logic       zero_a, zero_b, at_max_a, at_max_b;
    logic       hit_a, hit_b, ovf_a, ovf_b, unf_a, unf_b;
    logic       err_a, err_b;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(8), .MAX_VAL(64'd9), .RESET_VAL(64'd0)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .step(step), .sat_mode(sat_mode), .target(target),
`ifdef CONTADOR_ERR_STICKY_EN
        .err_clr(err_clr), .err_sticky(err_a),
`endif
        .count(count_a), .zero(zero_a), .at_max(at_max_a), .hit_target(hit_a),
        .ovf(ovf_a), .unf(unf_a)
    );

    contador_param #(.WIDTH(8), .MAX_VAL(64'd99), .RESET_VAL(64'd3)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up_down(up_down), .step(step), .sat_mode(sat_mode), .target(target),
`ifdef CONTADOR_ERR_STICKY_EN
        .err_clr(err_clr), .err_sticky(err_b),
`endif
        .count(count_b), .zero(zero_b), .at_max(at_max_b), .hit_target(hit_b),
        .ovf(ovf_b), .unf(unf_b)
    );

`ifndef CONTADOR_ERR_STICKY_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    typedef struct {
        int cnt;
        bit hit, ovf, unf, err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, one slot per instance.
    int   m_cnt[2];
    bit   m_err[2];
    bit   m_pls[2];
    int   MX[2] = '{9, 99};
    int   RV[2] = '{0, 3};

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        int   oc;
        bit   oh, oo, ou, oz, om, oe;
        for (int i = 0; i < 2; i++) begin
            if (sb.size() == 0) begin
                check({tag, "/sb_empty"}, 1, 0);
                return;
            end
            e = sb.pop_front();
            if (i == 0) begin
                oc = int'(count_a); oh = hit_a; oo = ovf_a; ou = unf_a; oz = zero_a; om = at_max_a; oe = err_a;
            end else begin
                oc = int'(count_b); oh = hit_b; oo = ovf_b; ou = unf_b; oz = zero_b; om = at_max_b; oe = err_b;
            end
            check($sformatf("%s/%0d/count", tag, i), oc, e.cnt);
            check($sformatf("%s/%0d/hit", tag, i), int'(oh), int'(e.hit));
            check($sformatf("%s/%0d/ovf", tag, i), int'(oo), int'(e.ovf));
            check($sformatf("%s/%0d/unf", tag, i), int'(ou), int'(e.unf));
            check($sformatf("%s/%0d/zero", tag, i), int'(oz), int'(e.cnt == 0));
            check($sformatf("%s/%0d/at_max", tag, i), int'(om), int'(e.cnt == MX[i]));
`ifdef CONTADOR_ERR_STICKY_EN
            check($sformatf("%s/%0d/err", tag, i), int'(oe), int'(e.err));
`else
            if (oe) check($sformatf("%s/%0d/err", tag, i), int'(oe), 0);
`endif
        end
    endtask

    // Asynchronous reset between edges; checked 1 time unit later, no edge needed.
    task automatic rst_check(input string tag);
        exp_t e;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = RV[i]; m_err[i] = 1'b0; m_pls[i] = 1'b0;
            e.cnt = RV[i]; e.hit = 0; e.ovf = 0; e.unf = 0; e.err = 0;
            sb.push_back(e);
        end
        #1;
        compare(tag);
    endtask

    // One clocked step: drive at negedge, push model prediction, compare after posedge.
    task automatic cyc(input string tag, input bit c, input bit ld, input int lv,
                       input bit e_, input bit ud, input int st, input bit sm,
                       input int tg, input bit ec);
        exp_t e;
        int   n, r, m;
        bit   o, u;
        @(negedge clk);
        reset = 1'b0;
        clear = c; load = ld; load_val = 8'(lv); en = e_; up_down = ud;
        step = 8'(st); sat_mode = sm; target = 8'(tg); err_clr = ec;
        for (int i = 0; i < 2; i++) begin
            n = m_cnt[i]; o = 0; u = 0; m = MX[i] + 1;
            if (c)        n = RV[i];
            else if (ld)  n = (lv > MX[i]) ? MX[i] : lv;
            else if (e_) begin
                if (ud) begin
                    r = m_cnt[i] + st;
                    if (r > MX[i]) begin o = 1; n = sm ? MX[i] : r % m; end
                    else n = r;
                end else begin
                    r = m_cnt[i] - st;
                    if (r < 0) begin u = 1; n = sm ? 0 : ((r % m) + m) % m; end
                    else n = r;
                end
            end
            e.hit = (n != m_cnt[i]) && (n == tg);
            e.ovf = o; e.unf = u; e.cnt = n;
            if (o || u || m_pls[i]) m_err[i] = 1'b1;
            else if (ec)            m_err[i] = 1'b0;
            e.err = m_err[i];
            m_pls[i] = o | u;
            m_cnt[i] = n;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        #2;
        rst_check("reset");
        //   tag            clr ld lv   en ud st  sm tg   ec
        cyc("load8",        0, 1, 8,   0, 1, 0,  0, 200, 0);
        cyc("wrap_up_ovf",  0, 0, 0,   1, 1, 3,  0, 200, 0);
        cyc("hold",         0, 0, 0,   0, 1, 3,  0, 200, 0);
        cyc("load2",        0, 1, 2,   0, 0, 5,  1, 200, 0);
        cyc("sat_dn_unf",   0, 0, 0,   1, 0, 5,  1, 200, 0);
        cyc("sat_dn_rep",   0, 0, 0,   1, 0, 5,  1, 200, 0);
        cyc("clr_wins",     1, 1, 7,   1, 1, 1,  0, 200, 0);
        cyc("load_clamp",   0, 1, 200, 0, 1, 1,  1, 200, 0);
        cyc("sat_up_max",   0, 0, 0,   1, 1, 1,  1, 200, 0);
        cyc("step0",        0, 0, 0,   1, 1, 0,  0, 200, 0);
        cyc("load3",        0, 1, 3,   0, 1, 1,  0, 5,   0);
        cyc("up4",          0, 0, 0,   1, 1, 1,  0, 5,   0);
        cyc("up5_hit",      0, 0, 0,   1, 1, 1,  0, 5,   0);
        cyc("hold5",        0, 0, 0,   0, 1, 1,  0, 5,   0);
        cyc("tgt_chg",      0, 0, 0,   0, 1, 1,  0, 4,   0);
        cyc("tgt_back",     0, 0, 0,   0, 1, 1,  0, 5,   0);
        cyc("wrap_dn",      0, 0, 0,   1, 0, 7,  0, 200, 0);
        cyc("wrap_big",     0, 0, 0,   1, 1, 25, 0, 200, 0);
        cyc("errclr_unf",   0, 0, 0,   1, 0, 50, 0, 200, 1);
        cyc("errclr_1",     0, 0, 0,   0, 0, 0,  0, 200, 1);
        cyc("errclr_2",     0, 0, 0,   0, 0, 0,  0, 200, 1);
        cyc("pre_abort",    0, 0, 0,   1, 1, 9,  0, 200, 0);
        #2;
        rst_check("async_rst");
        cyc("post_rst",     0, 0, 0,   1, 1, 1,  0, 200, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: count/data width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: upper count bound; a value above 2**WIDTH-1 SHALL be an elaboration error.
REQ-003 SHALL have parameter RESET_VAL, default 0: count value after reset or clear; must be ≤ MAX_VAL.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clear  in  1  synchronous return to RESET_VAL.
REQ-007 SHALL have port load  in  1  synchronous load of load_val.
REQ-008 SHALL have port load_val  in  WIDTH  value to load.
REQ-009 SHALL have port en  in  1  count enable.
REQ-010 SHALL have port up_down  in  1  direction: 1 = add step, 0 = subtract step.
REQ-011 SHALL have port step  in  WIDTH  increment/decrement magnitude.
REQ-012 SHALL have port sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
REQ-013 SHALL have port target  in  WIDTH  compare value for hit_target.
REQ-014 SHALL have port count  out  WIDTH  registered count.
REQ-015 SHALL have port zero  out  1  combinational, count == 0.
REQ-016 SHALL have port at_max  out  1  combinational, count == MAX_VAL.
REQ-017 SHALL have port hit_target  out  1  registered one-cycle pulse.
REQ-018 SHALL have port ovf  out  1  registered one-cycle pulse: an up operation exceeded MAX_VAL.
REQ-019 SHALL have port unf  out  1  registered one-cycle pulse: a down operation went below 0.

Function
REQ-020 SHALL apply priority per edge: reset > clear > load > en; with none active, count holds and all pulses are 0.
REQ-021 SHALL clamp load_val above MAX_VAL to MAX_VAL on load; load SHALL NOT raise ovf/unf.
REQ-022 SHALL compute up/down results at WIDTH+1 bits internally, so no intermediate truncation occurs.
REQ-023 In wrap mode, SHALL set count to (count ± step) mod (MAX_VAL+1); e.g. MAX_VAL=9, count=8, step=3, up gives 1.
REQ-024 In saturate mode, SHALL clamp the result to MAX_VAL (up) or 0 (down).
REQ-025 SHALL pulse ovf in the cycle after an up operation whose unclamped result exceeds MAX_VAL, in both modes; unf likewise for results below 0.
REQ-026 With en=1 and step=0, count SHALL be unchanged and no pulse SHALL be raised.
REQ-027 SHALL pulse hit_target for exactly one cycle, coincident with the first cycle count equals target, when that value was reached through a load, clear or count update that changed count.
REQ-028 SHALL NOT pulse hit_target again while count remains equal to target, or when target changes to match a count that has not changed.
REQ-029 SHALL sample sat_mode, step and target every cycle; no latency beyond one clock from input to count.

Reset
REQ-030 While reset is high, SHALL force count=RESET_VAL, hit_target=0, ovf=0, unf=0 and the sticky error flag (when present) to 0, independent of clk.
REQ-031 SHALL count on the first rising edge after reset deasserts if en=1; reset asserted mid-operation SHALL abort it with no pulse.

Configuration
REQ-032 With macro CONTADOR_ERR_STICKY_EN defined, SHALL add input err_clr (1 bit) and output err_sticky (1 bit).
REQ-033 err_sticky SHALL set on any ovf/unf pulse and hold until err_clr is high at an edge; a set condition in the same cycle SHALL win over err_clr.
REQ-034 Without CONTADOR_ERR_STICKY_EN, the err_clr/err_sticky ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 SHALL place in shared package contador_pkg: direction constants UP/DOWN, mode constants WRAP/SAT, and the default width constant.
REQ-036 SHALL implement the arithmetic (add/sub, wrap, clamp, ovf/unf detect) in combinational sub-module contador_addsub, instantiated once.

Verification
REQ-037 WIDTH=8, MAX_VAL=9, wrap, count=8, step=3, up, en -> count=1, ovf pulse 1 cycle.
REQ-038 Saturate, count=2, step=5, down -> count=0, unf pulse; repeat -> count stays 0, unf pulses again.
REQ-039 load=1, en=1, clear=1 simultaneous, load_val=7 -> count=RESET_VAL; then load alone with load_val=200 (MAX_VAL=99) -> count=99, no ovf.
REQ-040 target=5, counting up by 1 from 3 -> hit_target high only in the cycle count=5; with en=0 holding at 5 -> no further pulse.
REQ-041 Assert reset asynchronously between edges mid-count -> count=RESET_VAL immediately, no pulses; first edge after release counts from RESET_VAL.
REQ-042 With CONTADOR_ERR_STICKY_EN: ovf pulse sets err_sticky; err_clr in same cycle as new unf -> err_sticky remains 1.
